// File: rtl/exec_unit_seq_pkg.sv
// Shared definitions for the multi-cycle execution unit: opcode map, FSM states, count-width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package exec_pkg;

    // Opcode map; the unit decodes a 4-bit opcode field.
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDA  = 4'd1;
    localparam logic [3:0] OP_LDB  = 4'd2;
    localparam logic [3:0] OP_LDO  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_INV  = 4'd9;
    localparam logic [3:0] OP_CLR  = 4'd10;
    localparam logic [3:0] OP_SHL  = 4'd11;
    localparam logic [3:0] OP_SHR  = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;
    localparam logic [3:0] OP_SNZA = 4'd14;
    localparam logic [3:0] OP_ACCA = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2
    } state_t;

    // Counter width able to hold any B value (shift amount) and the
    // multiply step count DATA_WIDTH.
    function automatic int shift_cnt_w(input int dw);
        return (dw > $clog2(dw + 1)) ? dw : $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Unsigned shift-add multiplier: a*b into a 2*DATA_WIDTH product.
// Latency: start sampled at edge t, product valid and done pulsing in the cycle after edge t+DATA_WIDTH-1.
// Backpressure: none; caller must not pulse start while busy (start is ignored nowhere, it restarts).
//
// Ports: clk, reset (sync, active-high), start, a, b -> busy, done (1-cycle pulse), product.
module shift_add_mul
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic                      busy,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   product
);
    localparam int W  = DATA_WIDTH;
    localparam int W2 = 2 * DATA_WIDTH;
    localparam int CW = shift_cnt_w(DATA_WIDTH);

    logic [W2-1:0] mcand_q;
    logic [W-1:0]  mplier_q;
    logic [W2-1:0] prod_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;

    logic [W2-1:0] a_ext;
    assign a_ext = {{W{1'b0}}, a};

    // The first partial product is folded into the start edge so that the
    // whole multiply completes in exactly W busy cycles of the caller.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else if (start) begin
            prod_q   <= b[0] ? a_ext : '0;
            mcand_q  <= a_ext << 1;
            mplier_q <= b >> 1;
            cnt_q    <= CW'(W - 1);
            done_q   <= (W == 1);
        end else if (cnt_q != '0) begin
            prod_q   <= prod_q + (mplier_q[0] ? mcand_q : '0);
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            done_q   <= (cnt_q == CW'(1));
        end else begin
            done_q   <= 1'b0;
        end
    end

    assign busy    = (cnt_q != '0);
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: rtl/exec_unit_seq.sv
// Multi-cycle execution unit: 16 opcodes over A, B, ACC, O; iterative shifts and shift-add multiply.
// Latency: single-cycle ops retire one cycle after accept; SHL/SHR take B cycles, MUL takes DATA_WIDTH cycles.
// Backpressure: instr_ready drops for the whole duration of a multi-cycle op; one op per clock otherwise.
//
// Ports: clk, reset (sync, active-high); instr_valid/instr_ready handshake with opcode and
// operand (A field upper half, B field lower half); cpu_out (O register), out_valid, done, carry.
module exec_unit_seq
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [OPCODE_WIDTH-1:0]   opcode,
    input  logic [2*DATA_WIDTH-1:0]   operand,
    output logic [2*DATA_WIDTH-1:0]   cpu_out,
    output logic                      out_valid,
    output logic                      done,
    output logic                      carry
);
    localparam int W  = DATA_WIDTH;
    localparam int W2 = 2 * DATA_WIDTH;
    localparam int CW = shift_cnt_w(DATA_WIDTH);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, b_q;
    logic [W2-1:0] acc_q, o_q;
    logic [CW-1:0] cnt_q;
    logic          shl_q;
    logic          carry_q, skip_q, done_q, out_vld_q;

    logic          accept, exec;
    logic          is_shift;
    logic          mul_start, mul_busy, mul_done;
    logic          shift_last, mul_last;
    logic [W2-1:0] mul_product;

    logic [W2-1:0] a_ext, b_ext;
    logic [W2:0]   acca_sum;

    function automatic logic [W2-1:0] shift1(input logic [W2-1:0] v, input logic left);
        return left ? {v[W2-2:0], 1'b0} : {1'b0, v[W2-1:1]};
    endfunction

    assign a_ext    = {{W{1'b0}}, a_q};
    assign b_ext    = {{W{1'b0}}, b_q};
    assign acca_sum = {1'b0, acc_q} + {1'b0, a_ext};

    assign instr_ready = (state_q == S_IDLE) && !mul_busy;
    assign accept      = instr_valid && instr_ready;
    // A pending skip swallows the next accepted instruction entirely.
    assign exec        = accept && !skip_q;
    assign is_shift    = (opcode == OP_SHL) || (opcode == OP_SHR);

    always_comb begin
        state_d    = state_q;
        mul_start  = 1'b0;
        shift_last = 1'b0;
        mul_last   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (exec) begin
                    if (is_shift && (b_q != '0)) begin
                        state_d = S_SHIFT;
                    end else if (opcode == OP_MUL) begin
                        state_d   = S_MUL;
                        mul_start = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                // The final shift already landed on the previous edge, so
                // the count==1 cycle shows the result and retires.
                if (cnt_q == CW'(1)) begin
                    shift_last = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    mul_last = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            o_q       <= '0;
            cnt_q     <= '0;
            shl_q     <= 1'b0;
            carry_q   <= 1'b0;
            skip_q    <= 1'b0;
            done_q    <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= 1'b0;
            out_vld_q <= 1'b0;

            if (accept && skip_q) begin
                skip_q <= 1'b0;
            end else if (exec) begin
                case (opcode)
                    OP_NOP:  done_q <= 1'b1;
                    OP_LDA: begin
                        a_q    <= operand[W2-1:W];
                        done_q <= 1'b1;
                    end
                    OP_LDB: begin
                        b_q    <= operand[W-1:0];
                        done_q <= 1'b1;
                    end
                    OP_LDO: begin
                        o_q       <= acc_q;
                        out_vld_q <= 1'b1;
                        done_q    <= 1'b1;
                    end
                    OP_ADD: begin
                        acc_q   <= a_ext + b_ext;
                        carry_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    OP_SUB: begin
                        acc_q   <= a_ext - b_ext;
                        carry_q <= (a_q < b_q);
                        done_q  <= 1'b1;
                    end
                    OP_AND: begin
                        acc_q  <= a_ext & b_ext;
                        done_q <= 1'b1;
                    end
                    OP_OR: begin
                        acc_q  <= a_ext | b_ext;
                        done_q <= 1'b1;
                    end
                    OP_XOR: begin
                        acc_q  <= a_ext ^ b_ext;
                        done_q <= 1'b1;
                    end
                    OP_INV: begin
                        acc_q  <= ~acc_q;
                        done_q <= 1'b1;
                    end
                    OP_CLR: begin
                        acc_q   <= '0;
                        carry_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    OP_SHL, OP_SHR: begin
                        if (b_q == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            // First bit moves on the accept edge; the
                            // remaining B-1 bits move in SHIFT.
                            acc_q <= shift1(acc_q, opcode == OP_SHL);
                            shl_q <= (opcode == OP_SHL);
                            cnt_q <= CW'(b_q);
                        end
                    end
                    OP_MUL: ;
                    OP_SNZA: begin
                        if (a_q == '0) begin
                            skip_q <= 1'b1;
                        end
                        done_q <= 1'b1;
                    end
                    OP_ACCA: begin
                        acc_q   <= acca_sum[W2-1:0];
                        carry_q <= acca_sum[W2];
                        done_q  <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if ((state_q == S_SHIFT) && (cnt_q != CW'(1))) begin
                acc_q <= shift1(acc_q, shl_q);
                cnt_q <= cnt_q - CW'(1);
            end

            if (mul_last) begin
                acc_q <= mul_product;
            end
        end
    end

    shift_add_mul #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a_q),
        .b       (b_q),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign cpu_out   = o_q;
    assign out_valid = out_vld_q;
    assign carry     = carry_q;
    assign done      = done_q | shift_last | mul_last;

endmodule

// File: tb/tb_exec_unit_seq.sv
// Directed bench for exec_unit_seq at DATA_WIDTH=4 with hand-computed expectations.
// Latency: n/a.
// Backpressure: stimulus holds instr_valid until instr_ready, bounded by a cycle budget.
module tb_exec_unit_seq;
    logic       clk;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] opcode;
    logic [7:0] operand;
    logic [7:0] cpu_out;
    logic       out_valid;
    logic       done;
    logic       carry;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [3:0] NOP = 0, LDA = 1, LDB = 2, LDO = 3, ADD = 4, SUB = 5,
                           XOR = 8, INV = 9, CLR = 10, SHL = 11, SHR = 12,
                           MUL = 13, SNZA = 14, ACCA = 15;

    exec_unit_seq #(
        .DATA_WIDTH   (4),
        .OPCODE_WIDTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .cpu_out     (cpu_out),
        .out_valid   (out_valid),
        .done        (done),
        .carry       (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one instruction, waits (bounded) for ready, and returns #1
    // after the accepting edge, i.e. in the first cycle after accept.
    task automatic send(input logic [3:0] op, input logic [7:0] opnd);
        int guard;
        guard       = 0;
        instr_valid = 1'b1;
        opcode      = op;
        operand     = opnd;
        while (!instr_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("send_ready_timeout", 32'(instr_ready), 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        opcode      = NOP;
    endtask

    // Counts busy cycles from the current one; records the busy cycle index
    // in which done was seen (0 if never).
    task automatic wait_busy(output int n, output int done_at);
        n       = 0;
        done_at = 0;
        while (!instr_ready && n < 100) begin
            n++;
            if (done) done_at = n;
            @(posedge clk); #1;
        end
    endtask

    task automatic ldo_expect(input string tag, input logic [7:0] exp);
        send(LDO, 8'h00);
        check({tag, "_ov"}, 32'(out_valid), 32'd1);
        check({tag, "_out"}, 32'(cpu_out), 32'(exp));
    endtask

    int busy_n, done_at, done_seen;

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        opcode      = NOP;
        operand     = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_out",   32'(cpu_out),     32'd0);
        check("rst_ov",    32'(out_valid),   32'd0);
        check("rst_done",  32'(done),        32'd0);
        check("rst_carry", 32'(carry),       32'd0);

        // 3 + 5 = 8, out_valid exactly one cycle
        send(LDA, 8'h30);
        check("lda_done", 32'(done), 32'd1);
        send(LDB, 8'h05);
        send(ADD, 8'h00);
        ldo_expect("add", 8'h08);
        @(posedge clk); #1;
        check("add_ov_pulse", 32'(out_valid), 32'd0);

        // 2 - 7 wraps to 0xFB with borrow, then CLR
        send(LDA, 8'h20);
        send(LDB, 8'h07);
        send(SUB, 8'h00);
        ldo_expect("sub", 8'hFB);
        check("sub_carry", 32'(carry), 32'd1);
        send(CLR, 8'h00);
        ldo_expect("clr", 8'h00);
        check("clr_carry", 32'(carry), 32'd0);

        // 15 * 15 = 225; LDO held on valid during the busy window
        send(LDA, 8'hF0);
        send(LDB, 8'h0F);
        send(MUL, 8'h00);
        instr_valid = 1'b1;
        opcode      = LDO;
        wait_busy(busy_n, done_at);
        check("mul_busy", busy_n, 4);
        check("mul_done_at", done_at, 4);
        check("mul_no_early_ov", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        opcode      = NOP;
        check("mul_ldo_ov", 32'(out_valid), 32'd1);
        check("mul_out", 32'(cpu_out), 32'd225);

        // ACC = 1 via CLR + ACCA(A=1), then SHL by 3 -> 8
        send(CLR, 8'h00);
        send(LDA, 8'h10);
        send(ACCA, 8'h00);
        send(LDB, 8'h03);
        send(SHL, 8'h00);
        wait_busy(busy_n, done_at);
        check("shl3_busy", busy_n, 3);
        check("shl3_done_at", done_at, 3);
        ldo_expect("shl3", 8'h08);

        // SHR by 0 retires in one cycle, ACC unchanged
        send(LDB, 8'h00);
        send(SHR, 8'h00);
        check("shr0_ready", 32'(instr_ready), 32'd1);
        check("shr0_done", 32'(done), 32'd1);
        ldo_expect("shr0", 8'h08);

        // SHL by 9 (>= 8) clears ACC after 9 cycles
        send(LDB, 8'h09);
        send(SHL, 8'h00);
        wait_busy(busy_n, done_at);
        check("shl9_busy", busy_n, 9);
        ldo_expect("shl9", 8'h00);

        // Skip: ACC = 6, A = 0, SNZA swallows the next LDO
        send(LDA, 8'h50);
        send(LDB, 8'h01);
        send(ADD, 8'h00);
        send(LDA, 8'h00);
        send(SNZA, 8'h00);
        check("snza_done", 32'(done), 32'd1);
        send(LDO, 8'h00);
        check("skip_ov", 32'(out_valid), 32'd0);
        check("skip_done", 32'(done), 32'd0);
        check("skip_out", 32'(cpu_out), 32'd0);
        ldo_expect("after_skip", 8'h06);

        // ACCA carry-out: 0xFF + 1 -> 0, carry set
        send(CLR, 8'h00);
        send(INV, 8'h00);
        send(LDA, 8'h10);
        send(ACCA, 8'h00);
        check("acca_carry", 32'(carry), 32'd1);
        ldo_expect("acca", 8'h00);

        // XOR 10 ^ 6 = 12 (carry untouched, still 1)
        send(LDA, 8'hA0);
        send(LDB, 8'h06);
        send(XOR, 8'h00);
        ldo_expect("xor", 8'h0C);

        // Reset during MUL cycle 2
        send(LDA, 8'h30);
        send(LDB, 8'h04);
        send(MUL, 8'h00);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_ready", 32'(instr_ready), 32'd1);
        check("mrst_out",   32'(cpu_out),     32'd0);
        check("mrst_carry", 32'(carry),       32'd0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        check("mrst_no_done", done_seen, 0);

        // Fresh ADD after reset
        send(LDA, 8'h30);
        send(LDB, 8'h05);
        send(ADD, 8'h00);
        ldo_expect("post_rst_add", 8'h08);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exec_unit_seq.md
# exec_unit_seq

Parametrised, multi-cycle successor to the 4-bit CPU execution unit. It accepts one instruction per valid/ready handshake and executes 16 opcodes against A, B, ACC and O registers, with operand width set by `DATA_WIDTH`. Single-cycle ALU ops retire immediately. Shifts are iterative and take B cycles; multiply is shift-add and takes `DATA_WIDTH` cycles. It sits between the SPI instruction fetch and the output pins.

## Interface
- `DATA_WIDTH`, 4: width of A and B; ACC, O and `cpu_out` are 2*DATA_WIDTH.
- `OPCODE_WIDTH`, 4: opcode width; fixed at 4 for the current opcode map.
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  unit can accept; reset value 1.
- `opcode`  in  OPCODE_WIDTH  instruction opcode.
- `operand`  in  2*DATA_WIDTH  A field = upper half, B field = lower half.
- `cpu_out`  out  2*DATA_WIDTH  O register; reset value 0.
- `out_valid`  out  1  one-cycle pulse when `cpu_out` is updated; reset value 0.
- `done`  out  1  one-cycle pulse when an instruction retires; reset value 0.
- `carry`  out  1  sticky carry/borrow flag; reset value 0.

## Operation
- Accept occurs when `instr_valid && instr_ready`. Inputs are sampled only at accept.
- Opcode map (W = DATA_WIDTH, ACC = 2W bits, all unsigned, results mod 2^2W):
  - 0 NOP: no change.
  - 1 LDA: A <= operand[2W-1:W].
  - 2 LDB: B <= operand[W-1:0].
  - 3 LDO: O <= ACC; `out_valid` pulses.
  - 4 ADD: ACC <= A+B; carry <= 0.
  - 5 SUB: ACC <= A-B, wrapping at 2W bits; carry <= (A<B).
  - 6 AND, 7 OR, 8 XOR: ACC <= zero-extended A op B.
  - 9 INV: ACC <= ~ACC.
  - 10 CLR: ACC <= 0 and carry <= 0.
  - 11 SHL / 12 SHR: ACC shifted by B bits, zero fill, one bit per cycle.
  - 13 MUL: ACC <= A*B, unsigned shift-add.
  - 14 SNZA: if A==0, set skip.
  - 15 ACCA: ACC <= ACC+A; carry <= carry-out of bit 2W-1.
- Skip behaviour: while skip=1, the next accepted instruction has no effect and clears skip. It produces no `done` pulse and no `out_valid`. A skipped SNZA does not re-arm skip.
- FSM states: IDLE, SHIFT, MUL.
  - IDLE: `instr_ready`=1.
  - Accept SHL/SHR with B!=0 → SHIFT, count=B.
  - Accept MUL → MUL, count=W.
  - All other opcodes, and SHL/SHR with B==0, retire in IDLE.
  - SHIFT: one bit shift per cycle, count decrements; at count==1 the shift is applied, `done` pulses and the FSM returns to IDLE.
  - MUL: each cycle, if multiplier LSB is set, add the shifted multiplicand to the partial product; after W cycles, ACC <= product, `done` pulses, FSM returns to IDLE.
- Multi-cycle ops sample A and B into working registers at accept. An LDA/LDB cannot arrive mid-op because `instr_ready`=0.
- Shift by B ≥ 2W yields ACC=0 and still takes B cycles.
- Reset at any point, including mid-SHIFT or mid-MUL: return to IDLE; A, B, ACC, O, count, skip and carry all cleared; all outputs take their reset values next cycle.

## Timing
- Single-cycle ops accepted at edge t: register visible after t; `done` high during cycle t+1.
- LDO accepted at t: `cpu_out` updated and `out_valid`=1 during cycle t+1.
- SHL/SHR with B=n≥1 accepted at t:
  - `instr_ready`=0 for cycles t+1..t+n.
  - ACC final value and `done`=1 in cycle t+n.
  - `instr_ready`=1 in cycle t+n+1.
- MUL accepted at t: identical to shift with n=W (4 busy cycles at W=4).
- Throughput: one single-cycle op per clock. Back-to-back accepts are legal, and each sees the previous op's result.

## Structure
- Package `exec_pkg`:
  - opcode localparams (OP_NOP…OP_ACCA);
  - FSM state enum (S_IDLE, S_SHIFT, S_MUL);
  - helper function for the shift-count width.
- Sub-module `shift_add_mul`: W-cycle unsigned multiplier with start/busy/done, parameter DATA_WIDTH. The top FSM drives it.
- Everything else (decode, register file, ALU, shift counter) stays in the top module.

## Test plan
- W=4, reset, then LDA 3, LDB 5, ADD, LDO → `cpu_out`=8. `out_valid` pulses once, one cycle after the LDO accept.
- LDA 2, LDB 7, SUB, LDO → `cpu_out`=0xFB and carry=1. Then CLR, LDO → `cpu_out`=0 and carry=0.
- LDA 15, LDB 15, MUL → `instr_ready` low for exactly 4 cycles, then LDO gives `cpu_out`=225. A 5th-cycle `instr_valid` is held off until ready.
- ACC=1, then SHL with B=3 → 3 busy cycles, ACC=8. SHR with B=0 → single cycle, ACC unchanged. SHL with B=9 → ACC=0 after 9 cycles.
- LDA 0, SNZA, LDO → LDO skipped: no `out_valid`, no `done`. The following LDO executes normally.
- Assert `reset` during MUL cycle 2 → next cycle `instr_ready`=1, `cpu_out`=0, carry=0, no `done` pulse. A fresh ADD then works correctly.
